xif_coproc_rob: RTL and testbench
=================================

XIF_COPROC_ROB -- requirements
Module: xif_coproc_rob

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (power of two, 8..64).
- REQ-002 The block SHALL have parameter IMM_WIDTH, default 12, giving the immediate width taken from instr[31:32-IMM_WIDTH].
- REQ-003 The block SHALL have parameter DEPTH, default 4, giving the number of in-flight entries (power of two, 2..16).
- REQ-004 The block SHALL have parameter ID_WIDTH, default 4, giving the XIF instruction-id width.
- REQ-005 The block SHALL have the following ports, one per line as name, direction, width, meaning:
  - clk_i, in, 1, the single clock.
  - rst_i, in, 1, asynchronous active-high reset.
  - issue_valid_i, in, 1, issue request valid.
  - issue_ready_o, out, 1, issue ready.
  - issue_instr_i, in, 32, offloaded instruction.
  - issue_id_i, in, ID_WIDTH, instruction id.
  - issue_rs1_i, in, WIDTH, rs1 value.
  - issue_rs1_valid_i, in, 1, rs1 value valid.
  - issue_accept_o, out, 1, instruction recognised.
  - issue_writeback_o, out, 1, instruction writes rd.
  - commit_valid_i, in, 1, commit strobe.
  - commit_id_i, in, ID_WIDTH, id being committed or killed.
  - commit_kill_i, in, 1, 1 kills the instruction, 0 commits it.
  - result_valid_o, out, 1, result valid.
  - result_ready_i, in, 1, result ready.
  - result_id_o, out, ID_WIDTH, result id.
  - result_rd_o, out, 5, destination register.
  - result_we_o, out, 1, register write enable.
  - result_data_o, out, WIDTH, result value.
- REQ-006 Clock is clk_i only, and reset rst_i is asynchronous and active-high.

Function
- REQ-007 Decode SHALL be combinational: accepted iff instr[6:0]==7'b0001011 and funct3 instr[14:12] is 3'b000 (ADD: rs1 + sign-extended imm, modulo 2^WIDTH) or 3'b001 (ROL: rs1 rotated left by imm[log2(WIDTH)-1:0] bits).
- REQ-008 issue_accept_o and issue_writeback_o SHALL equal the decode result.
- REQ-009 issue_ready_o SHALL be (!full && issue_rs1_valid_i) for accepted instructions and 1 for unrecognised ones; a pop in the same cycle does not relieve full.
- REQ-010 An issue handshake (issue_valid_i && issue_ready_o && issue_accept_o) SHALL allocate the tail entry with {id, rd=instr[11:7], rs1, imm, op} in state ISSUED.
- REQ-011 Entry states SHALL be FREE, ISSUED, COMMITTED, KILLED and DONE.
- REQ-012 commit_valid_i SHALL move the single non-FREE entry whose id matches commit_id_i from ISSUED to KILLED if commit_kill_i=1, else to COMMITTED.
- REQ-013 A commit with no matching ISSUED entry SHALL be ignored.
- REQ-014 A commit whose id matches an issue handshake in the same cycle SHALL apply to the newly allocated entry.
- REQ-015 A single execution FSM {IDLE, BUSY} SHALL process entries in allocation order via an exec pointer.
- REQ-016 In IDLE, when the entry at the exec pointer is COMMITTED: ADD writes the result, marks the entry DONE and advances the pointer at the same edge; ROL with n=0 does the same; ROL with n>0 loads rs1 and counter=n and enters BUSY.
- REQ-017 In IDLE, when the entry at the exec pointer is KILLED, the pointer SHALL advance with no computation.
- REQ-018 In BUSY, each edge SHALL rotate by 1 and decrement the counter; at counter 1 the entry is marked DONE, the pointer advances and the FSM returns to IDLE.
- REQ-019 Retirement SHALL be in order from the head.
- REQ-020 A DONE head SHALL drive result_valid_o=1, result_we_o=1 and its id, rd and data; the head is freed on result_ready_i.
- REQ-021 A KILLED head already passed by the exec pointer SHALL be freed silently, one per cycle, with result_valid_o=0.
- REQ-022 When result_valid_o=0, result_id_o, result_rd_o, result_we_o and result_data_o SHALL be 0.
- REQ-023 Pointers SHALL wrap modulo DEPTH, and full/empty SHALL come from an occupancy counter 0..DEPTH.
- REQ-024 Simultaneous allocate and free SHALL leave the count unchanged.

Reset
- REQ-025 While rst_i=1 and on reset assertion at any time, including mid-BUSY, all entries SHALL go FREE, pointers, count and counter SHALL go to 0, the FSM SHALL go to IDLE and result_valid_o SHALL be 0.
- REQ-026 issue_ready_o SHALL follow REQ-009 with full=0 after reset.
- REQ-027 No result of a pre-reset instruction SHALL appear after reset.

Verification
- REQ-028 Bench SHALL cover: ADD, imm=-1, rs1=5, issue in cycle 0, commit in cycle 1, result_ready_i=1 -> result_valid_o=1 in cycle 3 with data=4.
- REQ-029 Bench SHALL cover: ROL, imm=4, rs1=32'h8000_0001, commit immediately -> data=32'h0000_0018, result_valid_o in cycle 7.
- REQ-030 Bench SHALL cover: issue ids 1, 2, 3, kill 2, commit 1 and 3 -> results for ids 1 then 3 only, in order.
- REQ-031 Bench SHALL cover: DEPTH accepted issues with no commits -> issue_ready_o=0 for a further valid instruction, while an unrecognised instruction still sees issue_ready_o=1 and issue_accept_o=0.
- REQ-032 Bench SHALL cover: result_ready_i held 0 for 10 cycles with a DONE head -> result outputs stable and the next entry is not lost.
- REQ-033 Bench SHALL cover: rst_i pulsed during BUSY of a ROL with imm=20 -> no result thereafter, and a new ADD completes normally.

Source files
------------

// File: rtl/xif_coproc_rob.sv
// xif_coproc_rob: small XIF coprocessor with an in-order reorder buffer.
// Offloaded custom-0 ADD/ROL instructions are queued, committed or killed
// by the core, executed in allocation order and retired from the head.
//
// Entry state | meaning
// FREE        | slot unused
// ISSUED      | allocated, waiting for commit/kill from the core
// COMMITTED   | may execute once the exec pointer reaches it
// KILLED      | dropped; skipped by exec, freed silently at the head
// DONE        | result held in the entry, waiting for result handshake
//
// Exec FSM    | meaning
// IDLE        | examining the entry at the exec pointer
// BUSY        | multi-cycle ROL, one bit of rotation per cycle
module xif_coproc_rob #(
  parameter int WIDTH     = 32,
  parameter int IMM_WIDTH = 12,
  parameter int DEPTH     = 4,
  parameter int ID_WIDTH  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [WIDTH-1:0]    issue_rs1_i,
  input  logic                issue_rs1_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic [WIDTH-1:0]    result_data_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(WIDTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  localparam logic [2:0] ST_FREE      = 3'd0;
  localparam logic [2:0] ST_ISSUED    = 3'd1;
  localparam logic [2:0] ST_COMMITTED = 3'd2;
  localparam logic [2:0] ST_KILLED    = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam logic [0:0] FSM_IDLE = 1'b0;
  localparam logic [0:0] FSM_BUSY = 1'b1;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  // Entry storage; ent_data_q holds rs1 until execution, then the result.
  logic [2:0]           ent_st_q   [DEPTH];
  logic [ID_WIDTH-1:0]  ent_id_q   [DEPTH];
  logic [4:0]           ent_rd_q   [DEPTH];
  logic                 ent_rol_q  [DEPTH];
  logic [IMM_WIDTH-1:0] ent_imm_q  [DEPTH];
  logic [WIDTH-1:0]     ent_data_q [DEPTH];

  logic [PW-1:0] head_q, tail_q, exec_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic [PW:0]   pend_q, pend_d;   // allocated entries not yet passed by exec
  logic [0:0]    fsm_q;
  logic [SW-1:0] cnt_q;
  logic [WIDTH-1:0] rot_q;

  // Decode
  logic dec_add, dec_rol, dec_acc, full, alloc;
  logic unused_instr_bits;

  assign dec_add = (issue_instr_i[6:0] == OPC_CUSTOM0) && (issue_instr_i[14:12] == 3'b000);
  assign dec_rol = (issue_instr_i[6:0] == OPC_CUSTOM0) && (issue_instr_i[14:12] == 3'b001);
  assign dec_acc = dec_add || dec_rol;
  assign unused_instr_bits = ^issue_instr_i[19:15];

  assign full              = (count_q == DEPTH_C);
  assign issue_accept_o    = dec_acc;
  assign issue_writeback_o = dec_acc;
  assign issue_ready_o     = dec_acc ? (!full && issue_rs1_valid_i) : 1'b1;
  assign alloc             = issue_valid_i && issue_ready_o && dec_acc;

  // Commit lookup; a same-cycle issue with the same id takes the commit itself.
  logic          cm_new, cm_hit;
  logic [PW-1:0] cm_idx;
  logic [2:0]    cm_state;

  assign cm_new   = commit_valid_i && alloc && (issue_id_i == commit_id_i);
  assign cm_state = commit_kill_i ? ST_KILLED : ST_COMMITTED;

  // Find the ISSUED entry matching the commit id
  always_comb begin
    cm_hit = 1'b0;
    cm_idx = '0;
    if (commit_valid_i && !cm_new) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!cm_hit && ent_st_q[i] == ST_ISSUED && ent_id_q[i] == commit_id_i) begin
          cm_hit = 1'b1;
          cm_idx = PW'(i);
        end
      end
    end
  end

  // Execution control
  logic [2:0]       exec_st;
  logic [SW-1:0]    ex_n;
  logic [WIDTH-1:0] ex_res;
  logic             ex_go, ex_skip, ex_start_busy, ex_done_now, busy_last, ex_adv;

  assign exec_st       = ent_st_q[exec_ptr_q];
  assign ex_n          = ent_imm_q[exec_ptr_q][SW-1:0];
  assign ex_go         = (fsm_q == FSM_IDLE) && (pend_q != '0) && (exec_st == ST_COMMITTED);
  assign ex_skip       = (fsm_q == FSM_IDLE) && (pend_q != '0) && (exec_st == ST_KILLED);
  assign ex_start_busy = ex_go && ent_rol_q[exec_ptr_q] && (ex_n != '0);
  assign ex_done_now   = ex_go && !ex_start_busy;
  assign busy_last     = (fsm_q == FSM_BUSY) && (cnt_q == SW'(1));
  assign ex_adv        = ex_done_now || ex_skip || busy_last;
  // A ROL with zero shift returns rs1 unchanged, so only ADD needs the adder.
  assign ex_res        = ent_rol_q[exec_ptr_q] ? ent_data_q[exec_ptr_q]
                       : ent_data_q[exec_ptr_q] + WIDTH'($signed(ent_imm_q[exec_ptr_q]));

  // Retirement
  logic [2:0] head_st;
  logic       retire_kill, retire;

  assign head_st        = ent_st_q[head_q];
  assign result_valid_o = (head_st == ST_DONE);
  assign retire_kill    = (head_st == ST_KILLED) && (count_q > pend_q);
  assign retire         = (result_valid_o && result_ready_i) || retire_kill;

  assign result_id_o   = result_valid_o ? ent_id_q[head_q]   : '0;
  assign result_rd_o   = result_valid_o ? ent_rd_q[head_q]   : '0;
  assign result_we_o   = result_valid_o;
  assign result_data_o = result_valid_o ? ent_data_q[head_q] : '0;

  // Next occupancy and pending counts
  always_comb begin
    count_d = count_q;
    if (alloc && !retire)      count_d = count_q + 1'b1;
    else if (!alloc && retire) count_d = count_q - 1'b1;
    pend_d = pend_q;
    if (alloc && !ex_adv)      pend_d = pend_q + 1'b1;
    else if (!alloc && ex_adv) pend_d = pend_q - 1'b1;
  end

  // Entry state transitions; alloc, commit, exec and retire touch distinct slots
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) ent_st_q[i] <= ST_FREE;
    end else begin
      if (alloc)                    ent_st_q[tail_q]     <= cm_new ? cm_state : ST_ISSUED;
      if (cm_hit)                   ent_st_q[cm_idx]     <= cm_state;
      if (ex_done_now || busy_last) ent_st_q[exec_ptr_q] <= ST_DONE;
      if (retire)                   ent_st_q[head_q]     <= ST_FREE;
    end
  end

  // Entry payload; validity is tracked by ent_st_q so no reset is needed
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      ent_id_q[tail_q]   <= issue_id_i;
      ent_rd_q[tail_q]   <= issue_instr_i[11:7];
      ent_rol_q[tail_q]  <= dec_rol;
      ent_imm_q[tail_q]  <= issue_instr_i[31:32-IMM_WIDTH];
      ent_data_q[tail_q] <= issue_rs1_i;
    end
    if (ex_done_now) ent_data_q[exec_ptr_q] <= ex_res;
    if (busy_last)   ent_data_q[exec_ptr_q] <= rol1(rot_q);
  end

  // Pointers and counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      exec_ptr_q <= '0;
      count_q    <= '0;
      pend_q     <= '0;
    end else begin
      if (alloc)  tail_q     <= tail_q + 1'b1;
      if (retire) head_q     <= head_q + 1'b1;
      if (ex_adv) exec_ptr_q <= exec_ptr_q + 1'b1;
      count_q <= count_d;
      pend_q  <= pend_d;
    end
  end

  // Exec FSM: multi-cycle rotate for ROL with a nonzero shift
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q <= FSM_IDLE;
      cnt_q <= '0;
      rot_q <= '0;
    end else begin
      case (fsm_q)
        FSM_IDLE: begin
          if (ex_start_busy) begin
            rot_q <= ent_data_q[exec_ptr_q];
            cnt_q <= ex_n;
            fsm_q <= FSM_BUSY;
          end
        end
        default: begin
          rot_q <= rol1(rot_q);
          cnt_q <= cnt_q - 1'b1;
          if (busy_last) fsm_q <= FSM_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xif_coproc_rob.sv
// Scoreboard bench for xif_coproc_rob: expected results are queued at issue
// and checked in order as the DUT hands them out.
module tb_xif_coproc_rob;

  localparam int WIDTH     = 32;
  localparam int IMM_WIDTH = 12;
  localparam int DEPTH     = 4;
  localparam int ID_WIDTH  = 4;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                issue_valid_i;
  logic                issue_ready_o;
  logic [31:0]         issue_instr_i;
  logic [ID_WIDTH-1:0] issue_id_i;
  logic [WIDTH-1:0]    issue_rs1_i;
  logic                issue_rs1_valid_i;
  logic                issue_accept_o;
  logic                issue_writeback_o;
  logic                commit_valid_i;
  logic [ID_WIDTH-1:0] commit_id_i;
  logic                commit_kill_i;
  logic                result_valid_o;
  logic                result_ready_i;
  logic [ID_WIDTH-1:0] result_id_o;
  logic [4:0]          result_rd_o;
  logic                result_we_o;
  logic [WIDTH-1:0]    result_data_o;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    logic [WIDTH-1:0]    data;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_i = ~clk_i;

  xif_coproc_rob #(
    .WIDTH(WIDTH), .IMM_WIDTH(IMM_WIDTH), .DEPTH(DEPTH), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs1_valid_i(issue_rs1_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_data_o(result_data_o)
  );

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [11:0] imm,
                                           input logic [4:0] rd);
    return {imm, 5'd0, f3, rd, 7'b0001011};
  endfunction

  function automatic exp_t mk_exp(input logic [ID_WIDTH-1:0] id, input logic [4:0] rd,
                                  input logic [WIDTH-1:0] data);
    exp_t e;
    e.id = id; e.rd = rd; e.data = data;
    return e;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_issue(input logic [2:0] f3, input logic [11:0] imm, input logic [4:0] rd,
                             input logic [ID_WIDTH-1:0] id, input logic [WIDTH-1:0] rs1);
    issue_valid_i     = 1'b1;
    issue_instr_i     = mk_instr(f3, imm, rd);
    issue_id_i        = id;
    issue_rs1_i       = rs1;
    issue_rs1_valid_i = 1'b1;
  endtask

  task automatic idle_issue();
    issue_valid_i     = 1'b0;
    issue_instr_i     = 32'h0;
    issue_id_i        = '0;
    issue_rs1_i       = '0;
    issue_rs1_valid_i = 1'b0;
  endtask

  task automatic drive_commit(input logic [ID_WIDTH-1:0] id, input logic kill);
    commit_valid_i = 1'b1;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic idle_commit();
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, inout int cyc);
    while (result_valid_o !== 1'b1 && cyc < max_cyc) begin
      step();
      cyc++;
    end
  endtask

  // Scoreboard: every accepted result must match the oldest expectation
  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (rst_i === 1'b0 && result_valid_o === 1'b1 && result_ready_i === 1'b1) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got id=%0d data=%h, required no result", result_id_o, result_data_o);
      end else begin
        e = sb_q.pop_front();
        if ({result_id_o, result_rd_o, result_we_o, result_data_o} !== {e.id, e.rd, 1'b1, e.data}) begin
          n_fail++;
          $display("FAIL result_sb: got id=%0d rd=%0d we=%b data=%h, required id=%0d rd=%0d we=1 data=%h",
                   result_id_o, result_rd_o, result_we_o, result_data_o, e.id, e.rd, e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst_i = 1'b1;
    idle_issue();
    idle_commit();
    result_ready_i = 1'b1;
    repeat (2) step();
    drive_issue(3'b000, 12'd1, 5'd1, 4'd1, 32'd1);
    #1;
    n_tests++;
    if ({issue_ready_o, issue_accept_o, result_valid_o, result_we_o, result_id_o, result_rd_o, result_data_o}
        !== {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b acc=%b rv=%b we=%b id=%0d rd=%0d data=%h, required rdy=1 acc=1 rv=0 rest 0",
               issue_ready_o, issue_accept_o, result_valid_o, result_we_o, result_id_o, result_rd_o, result_data_o);
    end
    idle_issue();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_add();
    drive_issue(3'b000, 12'hFFF, 5'd3, 4'd5, 32'd5);
    sb_q.push_back(mk_exp(4'd5, 5'd3, 32'd4));
    #1;
    n_tests++;
    if ({issue_ready_o, issue_accept_o, issue_writeback_o} !== 3'b111) begin
      n_fail++;
      $display("FAIL add_issue_hs: got rdy/acc/wb=%b, required 111", {issue_ready_o, issue_accept_o, issue_writeback_o});
    end
    step();
    idle_issue();
    drive_commit(4'd5, 1'b0);
    step();
    idle_commit();
    n_tests++;
    if (result_valid_o !== 1'b0 || result_data_o !== 32'd0) begin
      n_fail++;
      $display("FAIL add_cycle2: got valid=%b data=%h, required valid=0 data=0", result_valid_o, result_data_o);
    end
    step();
    n_tests++;
    if (result_valid_o !== 1'b1 || result_data_o !== 32'd4) begin
      n_fail++;
      $display("FAIL add_cycle3: got valid=%b data=%h, required valid=1 data=4", result_valid_o, result_data_o);
    end
    repeat (3) step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL add_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_rol();
    int cyc;
    drive_issue(3'b001, 12'd4, 5'd9, 4'd6, 32'h8000_0001);
    sb_q.push_back(mk_exp(4'd6, 5'd9, 32'h0000_0018));
    step();
    cyc = 1;
    idle_issue();
    drive_commit(4'd6, 1'b0);
    step();
    cyc++;
    idle_commit();
    wait_valid(40, cyc);
    n_tests++;
    if (cyc != 7 || result_data_o !== 32'h0000_0018) begin
      n_fail++;
      $display("FAIL rol_timing: got cycle=%0d data=%h, required cycle=7 data=00000018", cyc, result_data_o);
    end
    repeat (3) step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rol_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    // ADD wrapping to zero, committed in its own issue cycle
    drive_issue(3'b000, 12'd1, 5'd1, 4'd7, 32'hFFFF_FFFF);
    drive_commit(4'd7, 1'b0);
    sb_q.push_back(mk_exp(4'd7, 5'd1, 32'h0));
    step();
    // ROL by 32 uses shift 0: completes like an ADD with rs1 unchanged
    drive_issue(3'b001, 12'h020, 5'd2, 4'd8, 32'hA5A5_0F0F);
    drive_commit(4'd8, 1'b0);
    sb_q.push_back(mk_exp(4'd8, 5'd2, 32'hA5A5_0F0F));
    step();
    idle_issue();
    idle_commit();
    n_tests++;
    if (result_valid_o !== 1'b1 || result_id_o !== 4'd7 || result_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL b2b_add_wrap: got valid=%b id=%0d data=%h, required valid=1 id=7 data=0",
               result_valid_o, result_id_o, result_data_o);
    end
    step();
    n_tests++;
    if (result_valid_o !== 1'b1 || result_id_o !== 4'd8 || result_data_o !== 32'hA5A5_0F0F) begin
      n_fail++;
      $display("FAIL b2b_rol0: got valid=%b id=%0d data=%h, required valid=1 id=8 data=a5a50f0f",
               result_valid_o, result_id_o, result_data_o);
    end
    repeat (3) step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_kill();
    for (int i = 1; i <= 3; i++) begin
      drive_issue(3'b000, 12'd1, 5'(i + 3), 4'(i), 32'(i * 10));
      if (i != 2) sb_q.push_back(mk_exp(4'(i), 5'(i + 3), 32'(i * 10 + 1)));
      step();
    end
    idle_issue();
    drive_commit(4'd2, 1'b1);
    step();
    drive_commit(4'd1, 1'b0);
    step();
    drive_commit(4'd3, 1'b0);
    step();
    idle_commit();
    repeat (15) step();
    n_tests++;
    if (sb_q.size() != 0 || issue_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_drain: got %0d pending rdy=%b, required 0 pending rdy=1", sb_q.size(), issue_ready_o);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive_issue(3'b000, 12'd2, 5'(i + 20), 4'(i + 8), 32'(i * 3));
      sb_q.push_back(mk_exp(4'(i + 8), 5'(i + 20), 32'(i * 3 + 2)));
      step();
    end
    drive_issue(3'b000, 12'd2, 5'd30, 4'd12, 32'd99);
    #1;
    n_tests++;
    if (issue_ready_o !== 1'b0 || issue_accept_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_ready: got rdy=%b acc=%b, required rdy=0 acc=1", issue_ready_o, issue_accept_o);
    end
    step();
    issue_instr_i = 32'h0000_0033;
    #1;
    n_tests++;
    if ({issue_ready_o, issue_accept_o, issue_writeback_o} !== 3'b100) begin
      n_fail++;
      $display("FAIL full_unrecognised: got rdy/acc/wb=%b, required 100",
               {issue_ready_o, issue_accept_o, issue_writeback_o});
    end
    step();
    idle_issue();
    for (int i = 0; i < DEPTH; i++) begin
      drive_commit(4'(i + 8), 1'b0);
      step();
    end
    idle_commit();
    repeat (15) step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_hold();
    int cyc;
    result_ready_i = 1'b0;
    drive_issue(3'b000, 12'd3, 5'd10, 4'd12, 32'd100);
    sb_q.push_back(mk_exp(4'd12, 5'd10, 32'd103));
    step();
    drive_issue(3'b000, 12'hFF8, 5'd11, 4'd13, 32'd7);
    drive_commit(4'd12, 1'b0);
    sb_q.push_back(mk_exp(4'd13, 5'd11, 32'hFFFF_FFFF));
    step();
    idle_issue();
    drive_commit(4'd13, 1'b0);
    step();
    idle_commit();
    cyc = 0;
    wait_valid(20, cyc);
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (result_valid_o !== 1'b1 || result_id_o !== 4'd12 || result_rd_o !== 5'd10 || result_data_o !== 32'd103) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got valid=%b id=%0d rd=%0d data=%h, required valid=1 id=12 rd=10 data=67",
                 i, result_valid_o, result_id_o, result_rd_o, result_data_o);
      end
      step();
    end
    result_ready_i = 1'b1;
    repeat (6) step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL hold_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_busy();
    int cyc;
    bit seen;
    drive_issue(3'b001, 12'd20, 5'd12, 4'd14, 32'h1234_5678);
    step();
    idle_issue();
    drive_commit(4'd14, 1'b0);
    step();
    idle_commit();
    repeat (4) step();
    rst_i = 1'b1;
    #1;
    sb_q.delete();
    n_tests++;
    if (result_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_valid: got valid=%b, required 0", result_valid_o);
    end
    step();
    rst_i = 1'b0;
    step();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid_o !== 1'b0) seen = 1'b1;
      step();
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_stale: got stale result=%b, required 0", seen);
    end
    drive_issue(3'b000, 12'd5, 5'd13, 4'd15, 32'd10);
    sb_q.push_back(mk_exp(4'd15, 5'd13, 32'd15));
    step();
    cyc = 1;
    idle_issue();
    drive_commit(4'd15, 1'b0);
    step();
    cyc++;
    idle_commit();
    wait_valid(30, cyc);
    n_tests++;
    if (cyc != 3 || result_data_o !== 32'd15) begin
      n_fail++;
      $display("FAIL rst_busy_new_add: got cycle=%0d data=%h, required cycle=3 data=f", cyc, result_data_o);
    end
    repeat (3) step();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_busy_drain: got %0d pending, required 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_rol();
    test_back_to_back();
    test_kill();
    test_full();
    test_hold();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
